instr_cache_responder: RTL

- Direct-mapped, read-only instruction cache that serves the fetch stage's memory port.
- Accepts a fetch request carrying a program counter and returns the instruction word with a valid strobe.
- On a miss it refills a whole line from the lower memory over a single-outstanding word-read handshake.
- Sits between the fetch stage and main memory; also supports a full invalidate for fence.i.

---
 rtl/instr_cache_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instr_cache_responder.sv
// Direct-mapped, read-only instruction cache for the fetch port.
// Misses refill a full line over a single-outstanding word-read handshake.
`timescale 1ns/1ps
module instr_cache_responder #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        getir_istek_i,
  input  logic [31:0] getir_ps_i,
  output logic        getir_gecerli_o,
  output logic [31:0] getir_deger_o,
  output logic        getir_mesgul_o,
  input  logic        temizle_i,
  output logic        ana_istek_o,
  output logic [31:0] ana_adres_o,
  input  logic        ana_hazir_i,
  input  logic        ana_gecerli_i,
  input  logic [31:0] ana_veri_i
);

  localparam int unsigned OffW  = $clog2(LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned Ob    = 2 + OffW;
  localparam int unsigned TagW  = 32 - Ob - IdxW;
  localparam int unsigned Words = LINES * LINE_WORDS;

  typedef enum logic [1:0] {StIdle, StRefillReq, StRefillWait, StRespond} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [Words];

  logic [31:2]      pc_q, pc_d;
  logic [OffW-1:0]  cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             gecerli_q, gecerli_d;
  logic [31:0]      deger_q, deger_d;

  logic [IdxW-1:0]  req_idx, ref_idx;
  logic [TagW-1:0]  req_tag, ref_tag;
  logic [OffW-1:0]  req_off, ref_off;
  logic             lookup_hit, last_word, word_we, fill_done;
  logic             unused_ps;

  assign req_off = getir_ps_i[Ob-1:2];
  assign req_idx = getir_ps_i[Ob+IdxW-1:Ob];
  assign req_tag = getir_ps_i[31:Ob+IdxW];
  assign ref_off = pc_q[Ob-1:2];
  assign ref_idx = pc_q[Ob+IdxW-1:Ob];
  assign ref_tag = pc_q[31:Ob+IdxW];
  assign unused_ps = ^getir_ps_i[1:0];

  // A flush in the lookup cycle wins: the request is treated as a miss.
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !temizle_i;
  assign last_word  = (cnt_q == OffW'(LINE_WORDS - 1));
  assign word_we    = (state_q == StRefillWait) && ana_gecerli_i;
  assign fill_done  = word_we && last_word;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (getir_istek_i && !lookup_hit) state_d = StRefillReq;
      end
      StRefillReq: begin
        if (ana_hazir_i) state_d = StRefillWait;
      end
      StRefillWait: begin
        if (ana_gecerli_i) state_d = last_word ? StRespond : StRefillReq;
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ana_istek_o    = (state_q == StRefillReq);
    ana_adres_o    = '0;
    getir_mesgul_o = (state_q != StIdle);
    pc_d           = pc_q;
    cnt_d          = cnt_q;
    flush_pend_d   = flush_pend_q;
    valid_d        = valid_q;
    gecerli_d      = 1'b0;
    deger_d        = deger_q;

    if (state_q == StRefillReq) ana_adres_o = {pc_q[31:Ob], cnt_q, 2'b00};

    case (state_q)
      StIdle: begin
        if (getir_istek_i) begin
          if (lookup_hit) begin
            gecerli_d = 1'b1;
            deger_d   = data_q[{req_idx, req_off}];
          end else begin
            pc_d         = getir_ps_i[31:2];
            cnt_d        = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      StRefillReq: begin
        if (temizle_i) flush_pend_d = 1'b1;
      end
      StRefillWait: begin
        if (temizle_i) flush_pend_d = 1'b1;
        if (ana_gecerli_i && !last_word) cnt_d = cnt_q + OffW'(1);
        // A flush seen at any point of the refill keeps the line invalid.
        if (fill_done && !flush_pend_q && !temizle_i) valid_d[ref_idx] = 1'b1;
      end
      StRespond: begin
        // Response is registered, so the pulse appears the cycle after RESPOND.
        gecerli_d    = 1'b1;
        deger_d      = data_q[{ref_idx, ref_off}];
        flush_pend_d = 1'b0;
      end
      default: ;
    endcase

    if (temizle_i) valid_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      pc_q         <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      gecerli_q    <= 1'b0;
      deger_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      gecerli_q    <= gecerli_d;
      deger_q      <= deger_d;
    end
  end

  // Storage arrays carry no reset; only the valid bits qualify their contents.
  always_ff @(posedge clk_i) begin
    if (word_we) data_q[{ref_idx, cnt_q}] <= ana_veri_i;
    if (fill_done) tag_q[ref_idx] <= ref_tag;
  end

  assign getir_gecerli_o = gecerli_q;
  assign getir_deger_o   = deger_q;

endmodule
